// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - opcode, access-size and FSM-state definitions for the MEM stage
// Helpers: decode_size, decode_signed, is_misaligned, force_align, wb_select.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

    // Anything that is not a byte or half opcode is treated as a word access.
    function automatic mem_size_e decode_size(input logic [5:0] op);
        mem_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic decode_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] a);
        logic m;
        case (sz)
            SZ_HALF: m = a[0];
            SZ_WORD: m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Clears the low address bits that a half/word access is not allowed to use.
    function automatic logic [1:0] force_align(input mem_size_e sz, input logic [1:0] a);
        logic [1:0] r;
        case (sz)
            SZ_HALF: r = {a[1], 1'b0};
            SZ_WORD: r = 2'b00;
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] wb_select(
        input logic        pc_to_reg,
        input logic        mem_to_reg,
        input logic [31:0] pc,
        input logic [31:0] load_data,
        input logic [31:0] alu_res
    );
        logic [31:0] r;
        if (pc_to_reg)       r = pc + 32'd4;
        else if (mem_to_reg) r = load_data;
        else                 r = alu_res;
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte-lane steering for data-memory accesses
// size, addr_lo        : access width and low address bits (already aligned as required)
// load_signed          : sign-extend (lb/lh) instead of zero-extend (lbu/lhu)
// store_data/read_data : register store value / raw memory word
// be, wdata, load_data : byte enables, lane-replicated store word, extended load value
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic        load_signed,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b    = read_data[7:0];
        lane_h    = addr_lo[1] ? read_data[31:16] : read_data[15:0];
        be        = 4'b1111;
        wdata     = store_data;
        load_data = read_data;

        case (addr_lo)
            2'd0:    lane_b = read_data[7:0];
            2'd1:    lane_b = read_data[15:8];
            2'd2:    lane_b = read_data[23:16];
            default: lane_b = read_data[31:24];
        endcase

        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{load_signed & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{load_signed & lane_h[15]}}, lane_h};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = read_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS32 MEM stage: data-memory handshake FSM and MEM/WB register
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word instead of forcing alignment)
// clock, reset (sync, active-low)
// ex_*      : EX/MEM register contents (held by upstream while stall=1)
// stall     : combinational hold request to upstream
// dm_req_*  : registered request channel (valid/ready), dm_rsp_* : load response
// wb_*      : registered MEM/WB outputs; misalign : one-cycle trap flag
module mem_access_stage
    import mips_mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_ir,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_write_addr,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_pc_to_reg,
    input  logic        ex_reg_write,
    output logic        stall,
    output logic        dm_req_valid,
    input  logic        dm_req_ready,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_rsp_valid,
    input  logic [31:0] dm_rdata,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_ir,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_write_addr,
    output logic        wb_reg_write,
    output logic        misalign
);

    mem_state_e  state;
    mem_state_e  state_next;

    logic        access;
    mem_size_e   ex_size;
    logic        ex_signed;
    logic [1:0]  ex_lo;
    logic        ex_misalign;
    logic        start;
    logic        store_done;
    logic        load_done;

    // Instruction captured when the access starts; the request and the
    // eventual writeback are built from these, not from the live ex_* inputs.
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] alu_r;
    logic [4:0]  waddr_r;
    logic        mem_to_reg_r;
    logic        pc_to_reg_r;
    logic        reg_write_r;
    logic        signed_r;
    mem_size_e   size_r;

    mem_size_e   al_size;
    logic [1:0]  al_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    assign access    = ex_mem_read | ex_mem_write;
    assign ex_size   = decode_size(ex_ir[31:26]);
    assign ex_signed = decode_signed(ex_ir[31:26]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign ex_lo       = ex_alu_res[1:0];
    assign ex_misalign = access & is_misaligned(ex_size, ex_alu_res[1:0]);
`else
    assign ex_lo       = force_align(ex_size, ex_alu_res[1:0]);
    assign ex_misalign = 1'b0;
`endif

    // In IDLE the aligner builds the outgoing request from the live inputs;
    // afterwards it extracts the load lane from the captured access.
    assign al_size = (state == ST_IDLE) ? ex_size : size_r;
    assign al_lo   = (state == ST_IDLE) ? ex_lo   : dm_addr[1:0];

    mem_lane_align u_align (
        .size        (al_size),
        .addr_lo     (al_lo),
        .load_signed (signed_r),
        .store_data  (ex_rs2),
        .read_data   (dm_rdata),
        .be          (al_be),
        .wdata       (al_wdata),
        .load_data   (al_load)
    );

    always_ff @(posedge clock) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)        state_next = ST_REQ;
            ST_REQ:  if (dm_req_ready) state_next = dm_we ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (dm_rsp_valid) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // stall drops in the completion cycle so upstream advances on the same
    // edge that the finished instruction is written into MEM/WB.
    always_comb begin
        start      = (state == ST_IDLE) & access & ~ex_misalign;
        store_done = (state == ST_REQ)  & dm_req_ready & dm_we;
        load_done  = (state == ST_WAIT) & dm_rsp_valid;
        stall      = start
                   | ((state == ST_REQ)  & ~store_done)
                   | ((state == ST_WAIT) & ~load_done);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dm_req_valid  <= 1'b0;
            dm_addr       <= '0;
            dm_we         <= 1'b0;
            dm_be         <= '0;
            dm_wdata      <= '0;
            wb_pc         <= '0;
            wb_ir         <= '0;
            wb_result     <= '0;
            wb_write_addr <= '0;
            wb_reg_write  <= 1'b0;
            pc_r          <= '0;
            ir_r          <= '0;
            alu_r         <= '0;
            waddr_r       <= '0;
            mem_to_reg_r  <= 1'b0;
            pc_to_reg_r   <= 1'b0;
            reg_write_r   <= 1'b0;
            signed_r      <= 1'b0;
            size_r        <= SZ_BYTE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc_r         <= ex_pc;
                        ir_r         <= ex_ir;
                        alu_r        <= ex_alu_res;
                        waddr_r      <= ex_write_addr;
                        mem_to_reg_r <= ex_mem_to_reg;
                        pc_to_reg_r  <= ex_pc_to_reg;
                        reg_write_r  <= ex_reg_write;
                        signed_r     <= ex_signed;
                        size_r       <= ex_size;
                        dm_req_valid <= 1'b1;
                        dm_addr      <= {ex_alu_res[31:2], ex_lo};
                        dm_we        <= ex_mem_write;
                        dm_be        <= al_be;
                        dm_wdata     <= al_wdata;
                        wb_reg_write <= 1'b0;
                    end else begin
                        // Plain pass-through; a trapped access also lands here
                        // but never writes the register file.
                        wb_pc         <= ex_pc;
                        wb_ir         <= ex_ir;
                        wb_write_addr <= ex_write_addr;
                        wb_result     <= wb_select(ex_pc_to_reg, 1'b0, ex_pc, 32'd0, ex_alu_res);
                        wb_reg_write  <= ex_reg_write & ~ex_misalign;
                    end
                end
                ST_REQ: begin
                    if (dm_req_ready) dm_req_valid <= 1'b0;
                    if (store_done) begin
                        wb_pc         <= pc_r;
                        wb_ir         <= ir_r;
                        wb_write_addr <= waddr_r;
                        wb_result     <= wb_select(pc_to_reg_r, 1'b0, pc_r, 32'd0, alu_r);
                        wb_reg_write  <= reg_write_r;
                    end else begin
                        wb_reg_write  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (load_done) begin
                        wb_pc         <= pc_r;
                        wb_ir         <= ir_r;
                        wb_write_addr <= waddr_r;
                        wb_result     <= wb_select(pc_to_reg_r, mem_to_reg_r, pc_r, al_load, alu_r);
                        wb_reg_write  <= reg_write_r;
                    end else begin
                        wb_reg_write  <= 1'b0;
                    end
                end
                default: begin
                    dm_req_valid <= 1'b0;
                    wb_reg_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clock) begin
        if (!reset) misalign <= 1'b0;
        else        misalign <= ex_misalign & (state == ST_IDLE);
    end
`else
    assign misalign = 1'b0;
`endif

endmodule
